// File: rtl/wb_commit_unit.sv
// Writeback commit unit: in-order FIFO between MEM/WB and the GPR/CSR write ports.
// Optional commit trace outputs are built when DIFFTEST_EN is defined.
module wb_commit_unit #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [31:0]       in_inst,
  input  logic              in_rw_en,
  input  logic [4:0]        in_rw_addr,
  input  logic [31:0]       in_rw_data,
  input  logic              in_csr_en,
  input  logic [13:0]       in_csr_addr,
  input  logic [31:0]       in_csr_data,
  input  logic              csr_ready,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              csr_we,
  output logic [13:0]       csr_waddr,
  output logic [31:0]       csr_wdata,
  output logic              fwd_valid,
  output logic [4:0]        fwd_addr,
  output logic [31:0]       fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
`ifdef DIFFTEST_EN
  ,
  output logic              commit_valid,
  output logic [ADDR_W-1:0] commit_pc,
  output logic [31:0]       commit_inst
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
  localparam logic [CNT_W-1:0] ONE_RET  = CNT_W'(1);

  typedef struct packed {
    logic        rw_en;
    logic [4:0]  rw_addr;
    logic [31:0] rw_data;
    logic        csr_en;
    logic [13:0] csr_addr;
    logic [31:0] csr_data;
  } entry_t;

  // Handshake: an entry moves when in_valid && in_ready at a rising edge;
  // in_ready depends only on the registered occupancy, never on csr_ready.
  entry_t            mem [DEPTH];
  entry_t            head;
  entry_t            in_entry;
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;
  logic [PTR_W:0]    count;
  logic              empty;
  logic              push;
  logic              pop;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL_CNT);
  assign head     = (empty || rst) ? '0 : mem[head_ptr];

  assign in_entry = '{rw_en: in_rw_en, rw_addr: in_rw_addr, rw_data: in_rw_data,
                      csr_en: in_csr_en, csr_addr: in_csr_addr, csr_data: in_csr_data};

  assign push = !rst && !flush && in_valid && in_ready;
  // A stalled CSR write holds the whole head entry so GPR and CSR effects stay atomic.
  assign pop  = !rst && !flush && !empty && (!head.csr_en || csr_ready);

  assign rf_we     = pop && head.rw_en && (head.rw_addr != 5'd0);
  assign rf_waddr  = head.rw_addr;
  assign rf_wdata  = head.rw_data;
  assign csr_we    = pop && head.csr_en;
  assign csr_waddr = head.csr_addr;
  assign csr_wdata = head.csr_data;

  assign fwd_valid = head.rw_en && (head.rw_addr != 5'd0);
  assign fwd_addr  = head.rw_addr;
  assign fwd_data  = head.rw_data;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count      <= '0;
      retire_cnt <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail_ptr <= tail_ptr + ONE_PTR;
      end
      if (pop) begin
        head_ptr   <= head_ptr + ONE_PTR;
        retire_cnt <= retire_cnt + ONE_RET;
      end
      if (push && !pop) begin
        count <= count + ONE_CNT;
      end else if (pop && !push) begin
        count <= count - ONE_CNT;
      end
    end
  end

`ifdef DIFFTEST_EN
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_ptr]   <= in_pc;
      inst_mem[tail_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_inst  <= '0;
    end else begin
      commit_valid <= pop;
      if (pop) begin
        commit_pc   <= pc_mem[head_ptr];
        commit_inst <= inst_mem[head_ptr];
      end
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^{in_pc, in_inst};
`endif

endmodule
